// File: rtl/mem_mp_pkg.sv
// Shared types and helpers for the multi-channel single-port memory controller.
//
// Contents:
//   state_e  : init-clear FSM states (used when MEM_MP_INIT_CLEAR_EN is defined)
//   ch_idx   : (base + off) mod n, the channel visited at round-robin step off
package mem_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int unsigned ch_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mem_mp_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//
// Visits channels ptr, ptr+1, ... (mod N) and grants the first one whose
// req bit is set. The pointer register lives in the parent.
//
// Ports:
//   req      in  N     request vector (already qualified by the parent)
//   ptr      in  IW    channel with highest priority this cycle
//   gnt      out N     one-hot grant, or zero when nothing requests
//   gnt_idx  out IW    index of the granted channel (0 when none)
//   any_gnt  out 1     some channel was granted
module rr_arbiter
    import mem_mp_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'(ch_idx(32'(ptr), 32'(k), 32'(N)));
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_mp_ctrl.sv
// Multi-channel single-port memory controller.
//
// NUM_CH requesters share one DEPTH x DATA_WIDTH array. A round-robin
// arbiter grants at most one op (read or write) per cycle. Reads return one
// cycle after the grant, tagged with the requesting channel. A channel that
// raises rd_en and wr_en together is never granted and gets a 1-cycle err.
//
// Optional feature (macro MEM_MP_INIT_CLEAR_EN): after reset the array is
// zero-filled one word per cycle; busy is high for those DEPTH cycles and no
// requests are granted. Without the macro busy is tied low and the array is
// left uninitialised.
//
// Ports:
//   clk       in   1                   clock, posedge
//   rst       in   1                   synchronous active-high reset
//   wr_en     in   NUM_CH              per-channel write request
//   rd_en     in   NUM_CH              per-channel read request
//   addr      in   NUM_CH*ADDR_WIDTH   channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data   in   NUM_CH*DATA_WIDTH   channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt       out  NUM_CH              one-hot/zero grant, op executes this edge
//   rd_data   out  DATA_WIDTH          read data, valid with rd_valid
//   rd_valid  out  1                   read return strobe
//   rd_ch     out  CH_W                channel owning rd_data
//   err       out  NUM_CH              channel had rd_en & wr_en last cycle
//   busy      out  1                   not accepting requests (init clear)
module mem_mp_ctrl
    import mem_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            wr_en,
    input  logic [NUM_CH-1:0]            rd_en,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic [CH_W-1:0]              rd_ch,
    output logic [NUM_CH-1:0]            err,
    output logic                         busy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_CH-1:0]     elig;
    logic [CH_W-1:0]       gnt_idx;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]       rd_ch_q, rd_ch_d;
    logic [NUM_CH-1:0]     err_q, err_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    // ------------------------------------------------------------------
    // Init-clear FSM
    // ------------------------------------------------------------------
`ifdef MEM_MP_INIT_CLEAR_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            // Last word is written on the same edge that leaves CLEAR.
            if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        busy   = (state_q == CLEAR);
        // rst cycles must not touch the array.
        clr_we = (state_q == CLEAR) && !rst;
    end
`else
    always_comb begin
        busy = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Illegal rd_en & wr_en is simply not eligible; rst and busy mask all.
    always_comb begin
        elig = (rd_en ^ wr_en) & {NUM_CH{!rst && !busy}};
    end

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        req_addr  = addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        req_wdata = wr_data[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
        ptr_d     = any_gnt ? CH_W'(ch_idx(32'(gnt_idx), 32'd1, 32'(NUM_CH))) : ptr_q;
    end

    // ------------------------------------------------------------------
    // Array write port (granted write, or init clear; never both since
    // busy blocks grants)
    // ------------------------------------------------------------------
    always_comb begin
        mem_we = any_gnt && wr_en[gnt_idx];
        mem_wa = req_addr;
        mem_wd = req_wdata;
`ifdef MEM_MP_INIT_CLEAR_EN
        if (clr_we) begin
            mem_we = 1'b1;
            mem_wa = clr_addr_q;
            mem_wd = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read return and error registers
    // ------------------------------------------------------------------
    always_comb begin
        rd_valid_d = any_gnt && rd_en[gnt_idx];
        rd_data_d  = rd_valid_d ? mem[req_addr] : rd_data_q;
        rd_ch_d    = rd_valid_d ? gnt_idx : rd_ch_q;
        err_d      = rd_en & wr_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            err_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        rd_valid = rd_valid_q;
        rd_data  = rd_data_q;
        rd_ch    = rd_ch_q;
        err      = err_q;
    end

endmodule
